// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU results take priority, multi-cycle results bypass or queue in a small FIFO.
// Optional stall statistics counter is built only when WB_ARB_STATS_EN is defined.
module wb_arbiter #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        mc_valid,
   output logic        mc_ready,
   input  logic [4:0]  mc_rd,
   input  logic [31:0] mc_data,
   output logic        reg_write,
   output logic [4:0]  rd,
   output logic [31:0] wb_data,
   output logic        busy,
   output logic [15:0] stall_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [4:0]    buf_rd   [DEPTH];
   logic [31:0]   buf_data [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;

   logic        alu_claim;
   logic        mc_claim;
   logic        empty;
   logic        deq;
   logic        enq;
   logic        bypass;
   logic        win_valid;
   logic [4:0]  win_rd;
   logic [31:0] win_data;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign mc_ready = (count < CW'(DEPTH));
   assign busy     = (count != '0);

   always_comb begin
      alu_claim = alu_valid && (alu_rd != 5'd0);
      // x0 transfers still handshake but never reach the port or the buffer
      mc_claim  = mc_valid && mc_ready && (mc_rd != 5'd0);
      empty     = (count == '0);
      deq       = !alu_claim && !empty;
      bypass    = !alu_claim && empty && mc_claim;
      enq       = mc_claim && !bypass;
      win_valid = alu_claim || deq || bypass;
      win_rd    = alu_rd;
      win_data  = alu_data;
      if (!alu_claim && !empty) begin
         win_rd   = buf_rd[head];
         win_data = buf_data[head];
      end else if (bypass) begin
         win_rd   = mc_rd;
         win_data = mc_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         reg_write <= 1'b0;
         rd        <= '0;
         wb_data   <= '0;
         head      <= '0;
         tail      <= '0;
         count     <= '0;
      end else begin
         reg_write <= win_valid;
         if (win_valid) begin
            rd      <= win_rd;
            wb_data <= win_data;
         end
         if (deq) head <= ptr_next(head);
         if (enq) tail <= ptr_next(tail);
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only read while count says they are valid
   always_ff @(posedge clk) begin
      if (!reset && enq) begin
         buf_rd[tail]   <= mc_rd;
         buf_data[tail] <= mc_data;
      end
   end

`ifdef WB_ARB_STATS_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
      end else if (mc_valid && !mc_ready && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected writes are queued at stimulus time and
// popped by a negedge monitor whenever reg_write is seen.
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        mc_valid;
   logic        mc_ready;
   logic [4:0]  mc_rd;
   logic [31:0] mc_data;
   logic        reg_write;
   logic [4:0]  rd;
   logic [31:0] wb_data;
   logic        busy;
   logic [15:0] stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   logic [36:0] exp_q[$];
   logic [15:0] exp_stall;

   wb_arbiter #(.DEPTH(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .mc_valid  (mc_valid),
      .mc_ready  (mc_ready),
      .mc_rd     (mc_rd),
      .mc_data   (mc_data),
      .reg_write (reg_write),
      .rd        (rd),
      .wb_data   (wb_data),
      .busy      (busy),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   // Monitor: every write the DUT issues must match the next expected write
   always @(negedge clk) begin
      if (reg_write) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got rd=%0d data=%h, expected no write", rd, wb_data);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            if ({rd, wb_data} !== e) begin
               n_fail++;
               $display("FAIL write_order: got rd=%0d data=%h, expected rd=%0d data=%h",
                        rd, wb_data, e[36:32], e[31:0]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
      exp_q.push_back({r, d});
   endtask

   task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
      alu_valid = av; alu_rd = ar; alu_data = ad;
      mc_valid  = mv; mc_rd  = mr; mc_data  = md;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
   endtask

   initial begin
`ifdef WB_ARB_STATS_EN
      exp_stall = 16'd2;
`else
      exp_stall = 16'd0;
`endif
      reset = 1'b1;
      idle();
      idle();
      reset = 1'b0;
      chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
      chk("rst_rd", {27'd0, rd}, 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_mc_ready", {31'd0, mc_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_stall", {16'd0, stall_cnt}, 32'd0);

      // ALU only
      expect_wr(5'd5, 32'h1234);
      step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
      chk("alu_reg_write", {31'd0, reg_write}, 32'd1);
      chk("alu_rd", {27'd0, rd}, 32'd5);
      idle();
      chk("alu_idle_reg_write", {31'd0, reg_write}, 32'd0);
      chk("alu_idle_hold_rd", {27'd0, rd}, 32'd5);
      chk("alu_idle_hold_data", wb_data, 32'h1234);

      // Bypass with empty buffer
      expect_wr(5'd7, 32'hDEADBEEF);
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hDEADBEEF);
      chk("byp_reg_write", {31'd0, reg_write}, 32'd1);
      chk("byp_data", wb_data, 32'hDEADBEEF);
      chk("byp_busy", {31'd0, busy}, 32'd0);
      idle();

      // ALU/mc conflict: mc waits one cycle in the buffer
      expect_wr(5'd3, 32'hA);
      expect_wr(5'd4, 32'hB);
      step(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB);
      chk("cfl_rd_first", {27'd0, rd}, 32'd3);
      chk("cfl_busy_1", {31'd0, busy}, 32'd1);
      idle();
      chk("cfl_rd_second", {27'd0, rd}, 32'd4);
      chk("cfl_busy_0", {31'd0, busy}, 32'd0);
      idle();
      chk("cfl_idle", {31'd0, reg_write}, 32'd0);

      // Fill DEPTH=2 under continuous ALU traffic
      expect_wr(5'd1, 32'h101);
      expect_wr(5'd1, 32'h102);
      expect_wr(5'd1, 32'h103);
      expect_wr(5'd1, 32'h104);
      expect_wr(5'd8, 32'h80);
      expect_wr(5'd9, 32'h90);
      expect_wr(5'd10, 32'hA0);
      step(1'b1, 5'd1, 32'h101, 1'b1, 5'd8, 32'h80);
      chk("fill_ready_1", {31'd0, mc_ready}, 32'd1);
      step(1'b1, 5'd1, 32'h102, 1'b1, 5'd9, 32'h90);
      chk("fill_ready_full", {31'd0, mc_ready}, 32'd0);
      step(1'b1, 5'd1, 32'h103, 1'b1, 5'd10, 32'hA0);
      step(1'b1, 5'd1, 32'h104, 1'b1, 5'd10, 32'hA0);
      chk("fill_stall", {16'd0, stall_cnt}, {16'd0, exp_stall});
      chk("fill_busy", {31'd0, busy}, 32'd1);
      idle();
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hA0);
      idle();
      chk("fill_drained", {31'd0, busy}, 32'd0);
      idle();
      chk("fill_stall_hold", {16'd0, stall_cnt}, {16'd0, exp_stall});

      // x0 destinations never claim the port or the buffer
      step(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
      chk("x0_reg_write", {31'd0, reg_write}, 32'd0);
      chk("x0_busy", {31'd0, busy}, 32'd0);
      idle();

      // Reset with two entries buffered: those entries must never be written
      expect_wr(5'd2, 32'h201);
      expect_wr(5'd2, 32'h202);
      step(1'b1, 5'd2, 32'h201, 1'b1, 5'd11, 32'hB0);
      step(1'b1, 5'd2, 32'h202, 1'b1, 5'd12, 32'hC0);
      chk("rmid_busy_before", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      step(1'b1, 5'd13, 32'hD0, 1'b1, 5'd14, 32'hE0);
      reset = 1'b0;
      chk("rmid_reg_write", {31'd0, reg_write}, 32'd0);
      chk("rmid_busy", {31'd0, busy}, 32'd0);
      chk("rmid_mc_ready", {31'd0, mc_ready}, 32'd1);
      chk("rmid_stall", {16'd0, stall_cnt}, 32'd0);
      for (int i = 0; i < 4; i++) idle();

      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: DEPTH, default 2, the depth of the multi-cycle result buffer (legal values 2 or 4).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 alu_valid  input  1  single-cycle result present this cycle; no backpressure.
REQ-005 alu_rd  input  5  destination register of the ALU result.
REQ-006 alu_data  input  32  ALU result data.
REQ-007 mc_valid  input  1  multi-cycle (load/div/FPU) result offered.
REQ-008 mc_ready  output  1  result buffer can accept; equals (count < DEPTH), combinational from state only.
REQ-009 mc_rd  input  5  destination register of the multi-cycle result.
REQ-010 mc_data  input  32  multi-cycle result data.
REQ-011 reg_write  output  1  registered write enable to the register file.
REQ-012 rd  output  5  registered write address.
REQ-013 wb_data  output  32  registered write data.
REQ-014 busy  output  1  buffer non-empty.
REQ-015 stall_cnt  output  16  count of cycles in which the multi-cycle source was refused.

Function
REQ-016 The block is the single writer of the register-file write port; the register file samples reg_write/rd/wb_data on the falling edge, so the outputs are driven from rising-edge registers.
REQ-017 An mc transfer occurs on a rising edge with mc_valid && mc_ready.
REQ-018 An ALU result with alu_rd==0 is discarded and does not claim the port.
REQ-019 An mc transfer with mc_rd==0 is accepted and discarded, and is never enqueued.
REQ-020 Port arbitration per cycle, in priority order:
  - a claiming ALU result;
  - the buffer head;
  - a bypassed mc transfer (buffer empty);
  - idle.
REQ-021 A winner is loaded into {rd, wb_data} with reg_write=1 at the edge, giving one-cycle latency; an idle cycle loads reg_write=0, and rd/wb_data hold their previous values.
REQ-022 Bypass: an mc transfer arriving with the buffer empty and no claiming ALU result goes directly to the output register and does not change count.
REQ-023 An mc transfer that loses arbitration is enqueued at the tail.
REQ-024 The buffer is a circular FIFO with head/tail pointers wrapping at DEPTH.
REQ-025 count range is 0..DEPTH.
REQ-026 Simultaneous dequeue and enqueue leaves count unchanged and preserves order.
REQ-027 Full buffer: mc_ready=0 even if a dequeue occurs in the same cycle; no enqueue is allowed at full.
REQ-028 Buffered results write back in acceptance order.
REQ-029 WAW ordering between ALU and mc results is guaranteed by the upstream scoreboard, and this block does not reorder or check it.
REQ-030 stall_cnt increments on each cycle with mc_valid && !mc_ready.
REQ-031 stall_cnt saturates at 16'hFFFF.

Reset
REQ-032 While reset is high at a rising edge, the block clears the following and discards all buffered entries:
  - reg_write=0, rd=0, wb_data=0;
  - count=0 and both pointers=0;
  - stall_cnt=0.
REQ-033 Values after reset: mc_ready=1 and busy=0.
REQ-034 Reset asserted mid-operation takes precedence over all transfers in that cycle; no write is issued in the cycle after the reset edge.

Configuration
REQ-035 Macro WB_ARB_STATS_EN controls the stall counter.
REQ-036 With WB_ARB_STATS_EN defined, stall_cnt behaves per REQ-030, REQ-031 and REQ-032.
REQ-037 Without WB_ARB_STATS_EN, stall_cnt is tied to 16'h0000, no counter register is built, and all other behaviour is identical.

Verification
REQ-038 ALU only: alu_valid=1, alu_rd=5, alu_data=32'h1234 at edge N -> reg_write=1, rd=5, wb_data=32'h1234 after edge N, and reg_write=0 after edge N+1 when idle.
REQ-039 Bypass: buffer empty, no ALU, mc rd=7, data=32'hDEADBEEF -> written at the next edge, with busy staying 0.
REQ-040 Conflict: ALU (rd=3, 32'hA) and mc (rd=4, 32'hB) in the same cycle -> rd=3 written first, then rd=4 one cycle later, with busy=1 for exactly that one cycle.
REQ-041 Fill, DEPTH=2: ALU valid (rd=1) for 4 cycles while mc offers rd=8,9,10 back-to-back ->
  - 8 and 9 are enqueued;
  - mc_ready=0 in the third cycle;
  - stall_cnt=2 under WB_ARB_STATS_EN, otherwise 0;
  - after the ALU goes idle, the writes occur in the order 8, 9, 10.
REQ-042 x0: alu_rd=0 and mc_rd=0 in the same cycle, buffer empty -> no write is issued and count stays 0.
REQ-043 Reset mid-operation: with 2 entries buffered, assert reset for 1 cycle -> reg_write=0, busy=0, mc_ready=1 next cycle, and the discarded entries are never written.
